ysyx_23060184_wbu: RTL and testbench

//  Write-back stage directly downstream of the LSU in the multi-cycle NPC core.

---
 rtl/ysyx_23060184_wbu_pkg.sv | 21 ++
 rtl/ysyx_23060184_wbu_mux.sv | 27 ++
 rtl/ysyx_23060184_wbu.sv | 140 ++++++++++++++
 tb/tb_ysyx_23060184_wbu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_wbu_pkg.sv
// Shared definitions for the write-back unit.
// Holds the result-select encodings, the FSM state encodings and the register index width.
package ysyx_23060184_wbu_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned RESULT_SRC_LEN = 2;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_CSR = 2'b11
  } res_src_e;

  typedef enum logic [1:0] {
    WBU_IDLE   = 2'b00,
    WBU_COMMIT = 2'b01,
    WBU_HOLD   = 2'b10
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060184_wbu_mux.sv
// Write-back result select: combinational 4:1 mux.
// Inputs are the latched operands of the instruction being committed.
module ysyx_23060184_wbu_mux #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RESULT_SRC_LEN = ysyx_23060184_wbu_pkg::RESULT_SRC_LEN
) (
  input  logic [RESULT_SRC_LEN-1:0] sel,
  input  logic [DATA_WIDTH-1:0]     alu,
  input  logic [DATA_WIDTH-1:0]     mem,
  input  logic [DATA_WIDTH-1:0]     pc4,
  input  logic [DATA_WIDTH-1:0]     csr,
  output logic [DATA_WIDTH-1:0]     result
);
  import ysyx_23060184_wbu_pkg::*;

  always_comb begin
    result = alu;
    case (sel)
      RES_ALU: result = alu;
      RES_MEM: result = mem;
      RES_PC4: result = pc4;
      RES_CSR: result = csr;
      default: result = alu;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_wbu.sv
// Write-back stage: latches one retired instruction, writes rd once, then hands NextPC to the IFU.
// Optional retired-instruction counter (port instret) enabled by YSYX_23060184_WBU_INSTRET_EN.
module ysyx_23060184_wbu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = ysyx_23060184_wbu_pkg::REG_ADDR_WIDTH,
  parameter int unsigned RESULT_SRC_LEN = ysyx_23060184_wbu_pkg::RESULT_SRC_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Mvalid,
  output logic                      Wready,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     ReadData,
  input  logic [DATA_WIDTH-1:0]     PCPlus4,
  input  logic [DATA_WIDTH-1:0]     CsrRdata,
  input  logic [RESULT_SRC_LEN-1:0] ResultSrc,
  input  logic                      RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] Rd,
  input  logic [DATA_WIDTH-1:0]     NextPC,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      Wvalid,
  input  logic                      Iready,
`ifdef YSYX_23060184_WBU_INSTRET_EN
  output logic [63:0]               instret,
`endif
  output logic [DATA_WIDTH-1:0]     Wpc
);
  import ysyx_23060184_wbu_pkg::*;

  wbu_state_e                state;
  logic                      wready_q;
  logic                      wvalid_q;
  logic                      rf_wen_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     mem_q;
  logic [DATA_WIDTH-1:0]     pc4_q;
  logic [DATA_WIDTH-1:0]     csr_q;
  logic [RESULT_SRC_LEN-1:0] src_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     npc_q;

  // Handshake flags are registered; the write pulse is computed at latch time
  // so COMMIT always presents it for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WBU_IDLE;
      wready_q <= 1'b0;
      wvalid_q <= 1'b0;
      rf_wen_q <= 1'b0;
      alu_q    <= '0;
      mem_q    <= '0;
      pc4_q    <= '0;
      csr_q    <= '0;
      src_q    <= '0;
      rd_q     <= '0;
      npc_q    <= '0;
    end else begin
      case (state)
        WBU_IDLE: begin
          wready_q <= 1'b1;
          wvalid_q <= 1'b0;
          rf_wen_q <= 1'b0;
          if (Mvalid && wready_q) begin
            alu_q    <= ALUResult;
            mem_q    <= ReadData;
            pc4_q    <= PCPlus4;
            csr_q    <= CsrRdata;
            src_q    <= ResultSrc;
            rd_q     <= Rd;
            npc_q    <= NextPC;
            rf_wen_q <= RegWrite && (Rd != '0);
            wvalid_q <= 1'b1;
            wready_q <= 1'b0;
            state    <= WBU_COMMIT;
          end
        end
        WBU_COMMIT: begin
          rf_wen_q <= 1'b0;
          if (Iready) begin
            wvalid_q <= 1'b0;
            wready_q <= 1'b1;
            state    <= WBU_IDLE;
          end else begin
            state    <= WBU_HOLD;
          end
        end
        WBU_HOLD: begin
          rf_wen_q <= 1'b0;
          if (Iready) begin
            wvalid_q <= 1'b0;
            wready_q <= 1'b1;
            state    <= WBU_IDLE;
          end
        end
        default: begin
          wready_q <= 1'b0;
          wvalid_q <= 1'b0;
          rf_wen_q <= 1'b0;
          state    <= WBU_IDLE;
        end
      endcase
    end
  end

  ysyx_23060184_wbu_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .RESULT_SRC_LEN(RESULT_SRC_LEN)
  ) u_mux (
    .sel   (src_q),
    .alu   (alu_q),
    .mem   (mem_q),
    .pc4   (pc4_q),
    .csr   (csr_q),
    .result(rf_wdata)
  );

  assign Wready   = wready_q;
  assign Wvalid   = wvalid_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rd_q;
  assign Wpc      = npc_q;

`ifdef YSYX_23060184_WBU_INSTRET_EN
  logic [63:0] instret_q;

  // Every COMMIT cycle leaves COMMIT, so counting COMMIT cycles counts retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (state == WBU_COMMIT) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_ysyx_23060184_wbu.sv
// Directed self-checking bench for the write-back unit.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_ysyx_23060184_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mvalid;
  logic        Wready;
  logic [31:0] ALUResult;
  logic [31:0] ReadData;
  logic [31:0] PCPlus4;
  logic [31:0] CsrRdata;
  logic [1:0]  ResultSrc;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] NextPC;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        Wvalid;
  logic        Iready;
  logic [31:0] Wpc;
`ifdef YSYX_23060184_WBU_INSTRET_EN
  logic [63:0] instret;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060184_wbu #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .RESULT_SRC_LEN(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Mvalid   (Mvalid),
    .Wready   (Wready),
    .ALUResult(ALUResult),
    .ReadData (ReadData),
    .PCPlus4  (PCPlus4),
    .CsrRdata (CsrRdata),
    .ResultSrc(ResultSrc),
    .RegWrite (RegWrite),
    .Rd       (Rd),
    .NextPC   (NextPC),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .Wvalid   (Wvalid),
    .Iready   (Iready),
`ifdef YSYX_23060184_WBU_INSTRET_EN
    .instret  (instret),
`endif
    .Wpc      (Wpc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with Iready=1 and wait until the WBU is back in IDLE.
  task automatic retire(input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] npc);
    Mvalid    = 1'b1;
    ResultSrc = 2'b00;
    ALUResult = alu;
    RegWrite  = 1'b1;
    Rd        = rd;
    NextPC    = npc;
    Iready    = 1'b1;
    tick();
    Mvalid = 1'b0;
    tick();
  endtask

  int unsigned wv_cnt;
  int unsigned wen_cnt;

  initial begin
    rst = 1'b1; Mvalid = 1'b0; ALUResult = '0; ReadData = '0; PCPlus4 = '0;
    CsrRdata = '0; ResultSrc = '0; RegWrite = 1'b0; Rd = '0; NextPC = '0; Iready = 1'b0;
    tick();
    check("rst_wready", Wready, 0);
    check("rst_wvalid", Wvalid, 0);
    check("rst_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_wpc", Wpc, 0);
    rst = 1'b0;
    tick();
    check("idle_wready", Wready, 1);

    // Load result
    Mvalid = 1'b1; ResultSrc = 2'b01; ReadData = 32'hDEADBEEF; ALUResult = 32'h11111111;
    Rd = 5'd5; RegWrite = 1'b1; NextPC = 32'h80000100; Iready = 1'b1;
    tick();
    Mvalid = 1'b0;
    check("load_wen", rf_wen, 1);
    check("load_waddr", rf_waddr, 5);
    check("load_wdata", rf_wdata, 32'hDEADBEEF);
    check("load_wvalid", Wvalid, 1);
    check("load_wpc", Wpc, 32'h80000100);
    check("load_wready_busy", Wready, 0);
    tick();
    check("load_wready_back", Wready, 1);
    check("load_wvalid_drop", Wvalid, 0);
    check("load_wen_drop", rf_wen, 0);

    // Stall: Iready low for three cycles
    Mvalid = 1'b1; ResultSrc = 2'b00; ALUResult = 32'hCAFE0001; Rd = 5'd7;
    NextPC = 32'h80000200; Iready = 1'b0;
    tick();
    Mvalid = 1'b0;
    ALUResult = 32'h0; NextPC = 32'h0;
    check("stall_wdata", rf_wdata, 32'hCAFE0001);
    wv_cnt = 0; wen_cnt = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (Wvalid) wv_cnt++;
      if (rf_wen) wen_cnt++;
      check("stall_wpc", Wpc, 32'h80000200);
      check("stall_wready", Wready, 0);
      if (i == 3) Iready = 1'b1;
      tick();
    end
    check("stall_wvalid_cycles", wv_cnt, 4);
    check("stall_wen_pulses", wen_cnt, 1);
    check("stall_wvalid_end", Wvalid, 0);
    check("stall_wready_end", Wready, 1);

    // Write to x0 suppressed
    Mvalid = 1'b1; Rd = 5'd0; RegWrite = 1'b1; ResultSrc = 2'b00;
    ALUResult = 32'h1234; NextPC = 32'h80000300;
    tick();
    Mvalid = 1'b0;
    check("x0_wen", rf_wen, 0);
    check("x0_wvalid", Wvalid, 1);
    check("x0_wpc", Wpc, 32'h80000300);
    tick();
    check("x0_wen_after", rf_wen, 0);
    check("x0_wready", Wready, 1);

    // CSR select
    Mvalid = 1'b1; Rd = 5'd2; ResultSrc = 2'b11; CsrRdata = 32'h0000C5C5; NextPC = 32'h80000304;
    tick();
    Mvalid = 1'b0;
    check("csr_wdata", rf_wdata, 32'h0000C5C5);
    check("csr_wen", rf_wen, 1);
    tick();

    // Back-to-back jal with Mvalid held high
    Mvalid = 1'b1; ResultSrc = 2'b10; PCPlus4 = 32'h80000004; Rd = 5'd1; RegWrite = 1'b1;
    NextPC = 32'h80000040;
    tick();
    check("b2b_wen1", rf_wen, 1);
    check("b2b_wdata1", rf_wdata, 32'h80000004);
    PCPlus4 = 32'h80000010; NextPC = 32'h80000080;
    tick();
    check("b2b_gap_wen", rf_wen, 0);
    check("b2b_gap_wready", Wready, 1);
    tick();
    Mvalid = 1'b0;
    check("b2b_wen2", rf_wen, 1);
    check("b2b_wdata2", rf_wdata, 32'h80000010);
    check("b2b_wpc2", Wpc, 32'h80000080);
    tick();

    // Reset while in HOLD
    Mvalid = 1'b1; ResultSrc = 2'b00; ALUResult = 32'h55; Rd = 5'd3; Iready = 1'b0;
    tick();
    Mvalid = 1'b0;
    tick();
    check("hold_wvalid", Wvalid, 1);
    check("hold_wen", rf_wen, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsthold_wvalid", Wvalid, 0);
    check("rsthold_wen", rf_wen, 0);
    tick();
    check("rsthold_wready", Wready, 1);
    Iready = 1'b1; Mvalid = 1'b1; ALUResult = 32'h99; Rd = 5'd9; NextPC = 32'h80000400;
    tick();
    Mvalid = 1'b0;
    check("post_rst_wen", rf_wen, 1);
    check("post_rst_waddr", rf_waddr, 9);
    check("post_rst_wdata", rf_wdata, 32'h99);
    tick();

    // Mvalid together with rst: nothing latched
    rst = 1'b1; Mvalid = 1'b1; ALUResult = 32'h77; Rd = 5'd4;
    tick();
    rst = 1'b0; Mvalid = 1'b0;
    check("rstmv_wvalid", Wvalid, 0);
    check("rstmv_wen", rf_wen, 0);
    check("rstmv_wdata", rf_wdata, 0);
    tick();
    tick();
    check("rstmv_idle_wvalid", Wvalid, 0);

`ifdef YSYX_23060184_WBU_INSTRET_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("instret_rst", instret, 0);
    for (int unsigned k = 0; k < 10; k++) retire(32'h100 + k, 5'd6, 32'h80001000);
    check("instret_10", instret, 10);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    check("instret_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    retire(32'h1, 5'd6, 32'h80002000);
    check("instret_wrap", instret, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
